// File: rtl/conv_pool_mc.sv
// conv_pool_mc: streams 4x4 pixel blocks from RAM; N_KERNELS 3x3 convs -> 2x2 max/avg pool -> scale -> saturate.
// Latency: output_we for a block rises 5 cycles after its input_re; sustains 1 block/cycle.
// Backpressure: out_ready low freezes pipeline and output; reads throttle so the 2-entry skid never overflows.
// Option macro CONV_POOL_MC_RELU_EN: unsigned ReLU bytes; undefined gives signed saturated bytes.
module conv_pool_mc #(
  parameter int N_KERNELS  = 3,
  parameter int PIX_W      = 8,
  parameter int WGT_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int SHIFT_STEP = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W:0]              num_blocks,
  input  logic [1:0]                   shift,
  input  logic                         pool_mode,
  input  logic [N_KERNELS*9*WGT_W-1:0] conv_kernel,
  input  logic [16*PIX_W-1:0]          image_4x4,
  output logic                         input_re,
  output logic [ADDR_W-1:0]            input_addr,
  input  logic                         out_ready,
  output logic                         output_we,
  output logic [ADDR_W-1:0]            output_addr,
  output logic [N_KERNELS*8-1:0]       y,
  output logic                         busy,
  output logic                         done
);

  localparam int ACC_W = PIX_W + WGT_W + 5;
  localparam int SUM_W = ACC_W + 2;
  localparam int PRD_W = PIX_W + WGT_W + 1;
  localparam int CNT_W = ADDR_W + 1;

`ifdef CONV_POOL_MC_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(0);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(255);
`else
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  // configuration latched with start
  logic [CNT_W-1:0]               cfg_num;
  logic [1:0]                     cfg_shift;
  logic                           cfg_avg;
  logic [N_KERNELS*9*WGT_W-1:0]   cfg_kern;

  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  xfer_cnt;
  logic [ADDR_W-1:0] out_idx;

  // skid buffer for RAM data
  logic [16*PIX_W-1:0] skid_mem [2];
  logic                skid_rp, skid_wp;
  logic [1:0]          skid_cnt;
  logic                rd_inflight;
  logic [16*PIX_W-1:0] skid_head;
  logic [2:0]          skid_slots;

  // pipeline stages
  logic                    s1_vld, s2_vld;
  logic signed [PRD_W-1:0] s1_prod [N_KERNELS][4][9];
  logic signed [ACC_W-1:0] s2_pool [N_KERNELS];

  logic       advance, xfer, skid_pop;
  logic [5:0] shamt;

  assign advance    = !output_we || out_ready;
  assign xfer       = output_we && out_ready;
  assign skid_pop   = advance && (skid_cnt != 2'd0);
  assign skid_head  = skid_mem[skid_rp];
  assign input_addr = rd_cnt[ADDR_W-1:0];
  assign shamt      = 6'(cfg_shift) * 6'(SHIFT_STEP);
  // occupancy the skid will have after this cycle's pop, plus the read whose data is on the bus now
  assign skid_slots = {1'b0, skid_cnt} - {2'b0, skid_pop} + {2'b0, rd_inflight};

  // Read enable is combinational so a same-cycle pop frees a slot; without it throughput would halve.
  always_comb begin
    input_re = 1'b0;
    if (state == RUN && skid_slots < 3'd2) input_re = 1'b1;
  end

  // 4 window convolutions from the S1 products of kernel k, pooled to one value
  function automatic logic signed [ACC_W-1:0] pool_of(input int k, input logic avg);
    logic signed [ACC_W-1:0] cv [4];
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] mx;
    sum = '0;
    for (int w = 0; w < 4; w++) begin
      cv[w] = '0;
      for (int t = 0; t < 9; t++) cv[w] = cv[w] + ACC_W'(s1_prod[k][w][t]);
      sum = sum + SUM_W'(cv[w]);
    end
    mx = cv[0];
    for (int w = 1; w < 4; w++) if (cv[w] > mx) mx = cv[w];
    return avg ? ACC_W'(sum >>> 2) : mx;
  endfunction

  // arithmetic scale then clamp to the output byte range
  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] p, input logic [5:0] sa);
    logic signed [ACC_W-1:0] v;
    v = p >>> sa;
    if (v < SAT_LO) v = SAT_LO;
    else if (v > SAT_HI) v = SAT_HI;
    return v[7:0];
  endfunction

  // run control: config latch, read/transfer counting, busy and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_num   <= '0;
      cfg_shift <= '0;
      cfg_avg   <= 1'b0;
      cfg_kern  <= '0;
      rd_cnt    <= '0;
      xfer_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg_num   <= num_blocks;
          cfg_shift <= shift;
          cfg_avg   <= pool_mode;
          cfg_kern  <= conv_kernel;
          rd_cnt    <= '0;
          xfer_cnt  <= '0;
          if (num_blocks == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: if (input_re) begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (rd_cnt + CNT_W'(1) == cfg_num) state <= DRAIN;
        end
        DRAIN: ;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (xfer) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (xfer_cnt + CNT_W'(1) == cfg_num) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // skid pointers: capture whatever the RAM returns, pop when S1 advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      skid_rp     <= 1'b0;
      skid_wp     <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      rd_inflight <= input_re;
      if (rd_inflight) skid_wp <= ~skid_wp;
      if (skid_pop) skid_rp <= ~skid_rp;
      skid_cnt <= skid_cnt + {1'b0, rd_inflight} - {1'b0, skid_pop};
    end
  end

  // datapath registers: skid storage, S1 products, S2 pooled values
  always_ff @(posedge clk) begin
    if (rd_inflight) skid_mem[skid_wp] <= image_4x4;
    if (advance) begin
      for (int k = 0; k < N_KERNELS; k++) begin
        for (int w = 0; w < 4; w++) begin
          for (int t = 0; t < 9; t++) begin
            s1_prod[k][w][t] <=
              PRD_W'($signed({1'b0, skid_head[(4*(w/2 + t/3) + (w%2 + t%3))*PIX_W +: PIX_W]})) *
              PRD_W'($signed(cfg_kern[(9*k + t)*WGT_W +: WGT_W]));
          end
        end
        s2_pool[k] <= pool_of(k, cfg_avg);
      end
    end
  end

  // stage valids and output register; everything holds while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      output_we   <= 1'b0;
      output_addr <= '0;
      y           <= '0;
      out_idx     <= '0;
    end else begin
      if (state == IDLE && start) out_idx <= '0;
      if (advance) begin
        s1_vld    <= skid_pop;
        s2_vld    <= s1_vld;
        output_we <= s2_vld;
        if (s2_vld) begin
          for (int k = 0; k < N_KERNELS; k++) y[8*k +: 8] <= sat8(s2_pool[k], shamt);
          output_addr <= out_idx;
          out_idx     <= out_idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_mc.sv
// tb_conv_pool_mc: randomized and directed runs of conv_pool_mc against a queue-based scoreboard.
// RAM model returns a block one cycle after input_re; out_ready optionally random.
// Reference arithmetic is plain integer math on pixel/weight values.
module tb_conv_pool_mc;
  localparam int NK = 3;
  localparam int KW = NK * 9 * 8;

  logic          clk, rst_n, start;
  logic [16:0]   num_blocks;
  logic [1:0]    shift;
  logic          pool_mode;
  logic [KW-1:0] conv_kernel;
  logic [127:0]  image_4x4;
  logic          input_re;
  logic [15:0]   input_addr;
  logic          out_ready, output_we;
  logic [15:0]   output_addr;
  logic [23:0]   y;
  logic          busy, done;

  typedef struct packed {
    logic [15:0] addr;
    logic [23:0] y;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] img_mem [256];
  int           checks, failures, cyc, re_cnt, done_cnt, first_re, first_we;
  bit           rand_rdy, hold_vld;
  logic [15:0]  hold_addr;
  logic [23:0]  hold_y, last_y;

  conv_pool_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks), .shift(shift),
    .pool_mode(pool_mode), .conv_kernel(conv_kernel), .image_4x4(image_4x4),
    .input_re(input_re), .input_addr(input_addr), .out_ready(out_ready),
    .output_we(output_we), .output_addr(output_addr), .y(y), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // image RAM, one cycle read latency
  always @(posedge clk) if (input_re) image_4x4 <= img_mem[input_addr[7:0]];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int pix(input logic [127:0] img, input int r, input int c);
    logic [7:0] b;
    b = img[(4*r + c)*8 +: 8];
    return int'(b);
  endfunction

  function automatic int wgt(input logic [KW-1:0] kw, input int k, input int i, input int j);
    logic signed [7:0] b;
    b = kw[(9*k + 3*i + j)*8 +: 8];
    return int'(b);
  endfunction

  function automatic int floor_div(input int a, input int d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic logic [23:0] ref_y(input logic [127:0] img, input logic [KW-1:0] kw,
                                        input logic [1:0] sh, input bit avg);
    logic [23:0] res;
    int cv[4];
    int p, v;
    res = '0;
    for (int k = 0; k < NK; k++) begin
      for (int r0 = 0; r0 < 2; r0++) begin
        for (int c0 = 0; c0 < 2; c0++) begin
          cv[2*r0 + c0] = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              cv[2*r0 + c0] += pix(img, r0 + i, c0 + j) * wgt(kw, k, i, j);
        end
      end
      if (avg) p = floor_div(cv[0] + cv[1] + cv[2] + cv[3], 4);
      else begin
        p = cv[0];
        for (int w = 1; w < 4; w++) if (cv[w] > p) p = cv[w];
      end
      v = floor_div(p, 1 << (4 * int'(sh)));
`ifdef CONV_POOL_MC_RELU_EN
      if (v < 0) v = 0;
      if (v > 255) v = 255;
`else
      if (v < -128) v = -128;
      if (v > 127) v = 127;
`endif
      res[8*k +: 8] = 8'(v);
    end
    return res;
  endfunction

  // monitor: scoreboard pops on every transfer, stall stability, event counting
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (input_re) begin
        re_cnt++;
        if (first_re < 0) first_re = cyc;
      end
      if (done) done_cnt++;
      if (output_we && first_we < 0) first_we = cyc;
      if (hold_vld) begin
        chk("hold_we", longint'(output_we), 1);
        chk("hold_addr", longint'(output_addr), longint'(hold_addr));
        chk("hold_y", longint'(y), longint'(hold_y));
      end
      if (output_we && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output addr=%0d required=none", output_addr);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", longint'(output_addr), longint'(e.addr));
          chk("out_y", longint'(y), longint'(e.y));
          last_y = y;
        end
      end
      hold_vld  = output_we && !out_ready;
      hold_addr = output_addr;
      hold_y    = y;
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic push_exp(input int n, input logic [1:0] sh, input bit avg, input logic [KW-1:0] kw);
    for (int a = 0; a < n; a++) exp_q.push_back('{addr: 16'(a), y: ref_y(img_mem[a], kw, sh, avg)});
  endtask

  task automatic kick(input int n, input logic [1:0] sh, input bit avg, input logic [KW-1:0] kw);
    first_re   = -1;
    first_we   = -1;
    start      = 1'b1;
    num_blocks = 17'(n);
    shift      = sh;
    pool_mode  = avg;
    conv_kernel = kw;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_run(input int n, input logic [1:0] sh, input bit avg, input logic [KW-1:0] kw, input bit rr);
    int d0;
    push_exp(n, sh, avg, kw);
    rand_rdy = rr;
    d0 = done_cnt;
    kick(n, sh, avg, kw);
    chk("run_busy", longint'(busy), 1);
    for (int i = 0; i < 8*n + 50 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("run_done_once", done_cnt, d0 + 1);
    chk("run_busy_end", longint'(busy), 0);
    chk("run_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [KW-1:0] kw;
    int r0, d0;
    bit found;
    rst_n = 1'b0; start = 1'b0; num_blocks = '0; shift = '0; pool_mode = 1'b0;
    conv_kernel = '0; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_input_re", longint'(input_re), 0);
    chk("rst_input_addr", longint'(input_addr), 0);
    chk("rst_output_we", longint'(output_we), 0);
    chk("rst_output_addr", longint'(output_addr), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_we", longint'(output_we), 0);
    chk("idle_busy", longint'(busy), 0);

    // zero-length run
    r0 = re_cnt;
    d0 = done_cnt;
    kick(0, 2'd0, 1'b0, '0);
    chk("zero_done", longint'(done), 1);
    chk("zero_busy", longint'(busy), 0);
    @(posedge clk);
    #1;
    chk("zero_done_clr", longint'(done), 0);
    chk("zero_no_read", re_cnt, r0);
    chk("zero_done_cnt", done_cnt, d0 + 1);

    // all-ones block, kernel0 all +1, max
    img_mem[0] = '0;
    for (int b = 0; b < 16; b++) img_mem[0][b*8 +: 8] = 8'd1;
    kw = '0;
    for (int t = 0; t < 9; t++) kw[t*8 +: 8] = 8'd1;
    do_run(1, 2'd0, 1'b0, kw, 1'b0);
    chk("ones_y0", longint'(last_y[7:0]), 9);
    chk("ones_latency", first_we - first_re, 5);

    // saturating negative: pixels 255, kernel1 all -1
    for (int b = 0; b < 16; b++) img_mem[0][b*8 +: 8] = 8'hFF;
    kw = '0;
    for (int t = 0; t < 9; t++) kw[(9 + t)*8 +: 8] = 8'hFF;
    do_run(1, 2'd0, 1'b0, kw, 1'b0);
`ifdef CONV_POOL_MC_RELU_EN
    chk("neg_y1", longint'(last_y[15:8]), 0);
`else
    chk("neg_y1", longint'(last_y[15:8]), 128);
`endif

    // ramp image, kernel2 centre tap only
    for (int b = 0; b < 16; b++) img_mem[0][b*8 +: 8] = 8'(b);
    kw = '0;
    kw[22*8 +: 8] = 8'd1;
    do_run(1, 2'd0, 1'b1, kw, 1'b0);
    chk("ramp_avg_y2", longint'(last_y[23:16]), 7);
    do_run(1, 2'd0, 1'b0, kw, 1'b0);
    chk("ramp_max_y2", longint'(last_y[23:16]), 10);

    // randomized runs, random backpressure
    for (int a = 0; a < 256; a++) img_mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int run = 0; run < 4; run++) begin
      for (int b = 0; b < KW/8; b++) kw[b*8 +: 8] = 8'($urandom);
      do_run(100 + 30*run, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), kw, run != 0);
    end

    // reset in the middle of a run
    for (int b = 0; b < KW/8; b++) kw[b*8 +: 8] = 8'($urandom);
    push_exp(200, 2'd1, 1'b1, kw);
    rand_rdy = 1'b0;
    kick(200, 2'd1, 1'b1, kw);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (input_re && input_addr == 16'd100) found = 1'b1;
    end
    chk("mid_reached", longint'(found), 1);
    #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", longint'(output_we), 0);
    chk("mid_rst_y", longint'(y), 0);
    chk("mid_rst_addr", longint'(output_addr), 0);
    chk("mid_rst_re", longint'(input_re), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt, d0);
    chk("mid_idle_busy", longint'(busy), 0);
    do_run(4, 2'd0, 1'b0, kw, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
